// File: rtl/imem_arbiter.sv
// Instruction-memory bank arbiter between CPU fetch and load/store port, with lock/drain handoff.
// Optional starvation guard for the load port is enabled by defining IMEM_STARVE_GUARD_EN.
module imem_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_hold,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [3:0]        load_be,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_wdata,
  input  logic              load_lock,
  output logic              load_gnt,
  output logic              load_rvalid,
  output logic [31:0]       load_rdata,
  output logic [ADDR_W-1:0] bank_addr,
  output logic              bank_re,
  output logic [3:0]        bank_we,
  output logic [31:0]       bank_wdata,
  input  logic [31:0]       bank_rdata
);

  typedef enum logic [1:0] {ST_SHARED, ST_DRAIN, ST_LOCKED} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   load_boost;

`ifdef IMEM_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Saturating count of SHARED cycles in which a pending load was denied
  always_comb begin
    starve_d = starve_q;
    if (load_gnt) begin
      starve_d = '0;
    end else if (state_q == ST_SHARED && load_req && starve_q < CNT_W'(STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  assign load_boost = (starve_q >= CNT_W'(STARVE_MAX));
`else
  assign load_boost = 1'b0;
`endif

  // Grant decision: combinational from requests and current state
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_SHARED: begin
          if (fetch_req && !(load_req && load_boost)) fetch_gnt = 1'b1;
          else if (load_req)                          load_gnt  = 1'b1;
        end
        default: load_gnt = load_req;
      endcase
    end
  end

  // Bank port steering; idle bank sees zeros
  always_comb begin
    bank_addr  = '0;
    bank_re    = 1'b0;
    bank_we    = 4'b0000;
    bank_wdata = '0;
    if (fetch_gnt) begin
      bank_addr = fetch_addr;
      bank_re   = 1'b1;
    end else if (load_gnt) begin
      bank_addr  = load_addr;
      bank_re    = ~load_we;
      bank_we    = load_we ? load_be : 4'b0000;
      bank_wdata = load_wdata;
    end
  end

  // Next-state and read-owner tag
  always_comb begin
    state_d = state_q;
    owner_d = OWN_NONE;
    if (fetch_gnt)                owner_d = OWN_FETCH;
    else if (load_gnt && !load_we) owner_d = OWN_LOAD;
    case (state_q)
      ST_SHARED: if (load_lock) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!load_lock)                state_d = ST_SHARED;
        else if (owner_q != OWN_FETCH) state_d = ST_LOCKED;
      end
      ST_LOCKED: if (!load_lock) state_d = ST_SHARED;
      default: state_d = ST_SHARED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SHARED;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Read data arrives one cycle after grant straight from the synchronous bank
  assign fetch_rvalid = (owner_q == OWN_FETCH);
  assign load_rvalid  = (owner_q == OWN_LOAD);
  assign fetch_rdata  = fetch_rvalid ? bank_rdata : 32'h0;
  assign load_rdata   = load_rvalid  ? bank_rdata : 32'h0;
  assign fetch_hold   = (state_q != ST_SHARED);

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: read returns are queued at grant time and checked on return.
module tb_imem_arbiter;
  localparam int unsigned AW   = 14;
  localparam int unsigned SMAX = 8;

  logic          clk, rst;
  logic          fetch_req, fetch_gnt, fetch_rvalid, fetch_hold;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_rdata;
  logic          load_req, load_we, load_lock, load_gnt, load_rvalid;
  logic [3:0]    load_be;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_wdata, load_rdata;
  logic [AW-1:0] bank_addr;
  logic          bank_re;
  logic [3:0]    bank_we;
  logic [31:0]   bank_wdata, bank_rdata;

  typedef struct {
    bit          is_fetch;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  imem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_hold(fetch_hold),
    .load_req(load_req), .load_we(load_we), .load_be(load_be), .load_addr(load_addr),
    .load_wdata(load_wdata), .load_lock(load_lock), .load_gnt(load_gnt),
    .load_rvalid(load_rvalid), .load_rdata(load_rdata),
    .bank_addr(bank_addr), .bank_re(bank_re), .bank_we(bank_we),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
    if (a == AW'(4)) return 32'h0050_0093;
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Synchronous bank model; garbage when not read so leaks show up
  always @(posedge clk) bank_rdata <= bank_re ? mem_val(bank_addr) : 32'hDEAD_BEEF;

  task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr, input logic lwe,
                       input logic [3:0] lbe, input logic [AW-1:0] la, input logic [31:0] lwd,
                       input logic llk);
    fetch_req = fr; fetch_addr = fa; load_req = lr; load_we = lwe;
    load_be = lbe; load_addr = la; load_wdata = lwd; load_lock = llk;
    #1;
  endtask

  task automatic expect_read(input bit f, input logic [31:0] d);
    exp_t e;
    e.is_fetch = f; e.data = d; e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and compare any read return against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      total++; bad++;
      $display("FAIL lost_read: due cycle %0d, now %0d, no return seen", e.due, cyc);
    end
    total++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (fetch_rvalid !== e.is_fetch || load_rvalid !== !e.is_fetch ||
          (e.is_fetch ? fetch_rdata : load_rdata) !== e.data) begin
        bad++;
        $display("FAIL read_return cyc=%0d: got fv=%b lv=%b fd=%h ld=%h, want fetch=%b data=%h",
                 cyc, fetch_rvalid, load_rvalid, fetch_rdata, load_rdata, e.is_fetch, e.data);
      end
    end else if (fetch_rvalid !== 1'b0 || load_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL spurious_rvalid cyc=%0d: got fv=%b lv=%b, want 0 0", cyc, fetch_rvalid, load_rvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, AW'(4), 1'b1, 1'b1, 4'hF, AW'(8), 32'h1234_5678, 1'b0);
    total++;
    if ({fetch_gnt, load_gnt, fetch_rvalid, load_rvalid, fetch_hold, bank_re} !== 6'b0 ||
        bank_we !== 4'b0 || fetch_rdata !== 32'h0 || load_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got fg=%b lg=%b fv=%b lv=%b hold=%b re=%b we=%b fd=%h ld=%h, want all 0",
               fetch_gnt, load_gnt, fetch_rvalid, load_rvalid, fetch_hold, bank_re, bank_we,
               fetch_rdata, load_rdata);
    end
    tick();
    rst = 1'b0;
    drive(1'b1, AW'(4), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b0);
    total++;
    if (fetch_gnt !== 1'b1 || bank_addr !== AW'(4) || bank_re !== 1'b1 || bank_we !== 4'b0) begin
      bad++;
      $display("FAIL first_fetch: got gnt=%b addr=%h re=%b we=%b, want 1 0004 1 0000",
               fetch_gnt, bank_addr, bank_re, bank_we);
    end
    expect_read(1'b1, 32'h0050_0093);
    tick();
    drive(1'b0, AW'(0), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b0);
    total++;
    if (bank_re !== 1'b0 || bank_addr !== AW'(0) || bank_we !== 4'b0) begin
      bad++;
      $display("FAIL idle_bank: got re=%b addr=%h we=%b, want 0 0 0", bank_re, bank_addr, bank_we);
    end
    tick();
  endtask

  task automatic test_alternate();
    drive(1'b1, AW'('h20), 1'b1, 1'b0, 4'h0, AW'('h30), 32'h0, 1'b0);
    total++;
    if (fetch_gnt !== 1'b1 || load_gnt !== 1'b0 || bank_addr !== AW'('h20)) begin
      bad++;
      $display("FAIL fetch_priority: got fg=%b lg=%b addr=%h, want 1 0 0020", fetch_gnt, load_gnt, bank_addr);
    end
    expect_read(1'b1, mem_val(AW'('h20)));
    tick();
    drive(1'b0, AW'(0), 1'b1, 1'b0, 4'h0, AW'('h30), 32'h0, 1'b0);
    total++;
    if (load_gnt !== 1'b1 || fetch_gnt !== 1'b0 || bank_re !== 1'b1 || bank_we !== 4'b0 ||
        bank_addr !== AW'('h30)) begin
      bad++;
      $display("FAIL load_read_grant: got lg=%b fg=%b re=%b we=%b addr=%h, want 1 0 1 0 0030",
               load_gnt, fetch_gnt, bank_re, bank_we, bank_addr);
    end
    expect_read(1'b0, mem_val(AW'('h30)));
    tick();
    drive(1'b0, AW'(0), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_contention();
    bit exp_load;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, AW'('h100 + i), 1'b1, 1'b0, 4'h0, AW'('h200 + i), 32'h0, 1'b0);
`ifdef IMEM_STARVE_GUARD_EN
      exp_load = ((i % (SMAX + 1)) == SMAX);
`else
      exp_load = 1'b0;
`endif
      total++;
      if (fetch_gnt !== !exp_load || load_gnt !== exp_load) begin
        bad++;
        $display("FAIL contention[%0d]: got fg=%b lg=%b, want fg=%b lg=%b",
                 i, fetch_gnt, load_gnt, !exp_load, exp_load);
      end
      if (exp_load) expect_read(1'b0, mem_val(AW'('h200 + i)));
      else          expect_read(1'b1, mem_val(AW'('h100 + i)));
      tick();
    end
    drive(1'b0, AW'(0), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_lock();
    drive(1'b1, AW'('h40), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b1);
    total++;
    if (fetch_gnt !== 1'b1 || fetch_hold !== 1'b0) begin
      bad++;
      $display("FAIL lock_entry: got fg=%b hold=%b, want 1 0", fetch_gnt, fetch_hold);
    end
    expect_read(1'b1, mem_val(AW'('h40)));
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, AW'('h44), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b1);
      total++;
      if (fetch_gnt !== 1'b0 || fetch_hold !== 1'b1) begin
        bad++;
        $display("FAIL drain[%0d]: got fg=%b hold=%b, want 0 1", i, fetch_gnt, fetch_hold);
      end
      tick();
    end
    drive(1'b1, AW'('h44), 1'b1, 1'b1, 4'b0101, AW'('h10), 32'h1122_3344, 1'b1);
    total++;
    if (load_gnt !== 1'b1 || fetch_gnt !== 1'b0 || bank_we !== 4'b0101 || bank_re !== 1'b0 ||
        bank_addr !== AW'('h10) || bank_wdata !== 32'h1122_3344 || fetch_hold !== 1'b1) begin
      bad++;
      $display("FAIL locked_write: got lg=%b fg=%b we=%b re=%b addr=%h wd=%h hold=%b, want 1 0 0101 0 0010 11223344 1",
               load_gnt, fetch_gnt, bank_we, bank_re, bank_addr, bank_wdata, fetch_hold);
    end
    tick();
    drive(1'b1, AW'('h44), 1'b1, 1'b0, 4'h0, AW'('h14), 32'h0, 1'b1);
    total++;
    if (load_gnt !== 1'b1 || fetch_gnt !== 1'b0) begin
      bad++;
      $display("FAIL locked_read: got lg=%b fg=%b, want 1 0", load_gnt, fetch_gnt);
    end
    expect_read(1'b0, mem_val(AW'('h14)));
    tick();
    drive(1'b1, AW'('h44), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b0);
    total++;
    if (fetch_hold !== 1'b1 || fetch_gnt !== 1'b0) begin
      bad++;
      $display("FAIL unlock_cycle: got hold=%b fg=%b, want 1 0", fetch_hold, fetch_gnt);
    end
    tick();
    total++;
    if (fetch_hold !== 1'b0 || fetch_gnt !== 1'b1) begin
      bad++;
      $display("FAIL after_unlock: got hold=%b fg=%b, want 0 1", fetch_hold, fetch_gnt);
    end
    expect_read(1'b1, mem_val(AW'('h44)));
    tick();
    // Lock dropped while draining returns straight to shared
    drive(1'b0, AW'(0), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b1);
    tick();
    drive(1'b1, AW'('h48), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b0);
    total++;
    if (fetch_hold !== 1'b1 || fetch_gnt !== 1'b0) begin
      bad++;
      $display("FAIL drain_abort: got hold=%b fg=%b, want 1 0", fetch_hold, fetch_gnt);
    end
    tick();
    total++;
    if (fetch_hold !== 1'b0 || fetch_gnt !== 1'b1) begin
      bad++;
      $display("FAIL drain_abort_shared: got hold=%b fg=%b, want 0 1", fetch_hold, fetch_gnt);
    end
    expect_read(1'b1, mem_val(AW'('h48)));
    tick();
    drive(1'b0, AW'(0), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_reset_midread();
    drive(1'b1, AW'('h50), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b0);
    total++;
    if (fetch_gnt !== 1'b1) begin
      bad++;
      $display("FAIL midread_grant: got fg=%b, want 1", fetch_gnt);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (fetch_gnt !== 1'b0 || bank_re !== 1'b0) begin
      bad++;
      $display("FAIL midread_reset_gnt: got fg=%b re=%b, want 0 0", fetch_gnt, bank_re);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, AW'(0), 1'b0, 1'b0, 4'h0, AW'(0), 32'h0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0; load_req = 1'b0; load_we = 1'b0;
    load_be = 4'h0; load_addr = '0; load_wdata = '0; load_lock = 1'b0;
    @(negedge clk);
    test_reset();
    test_alternate();
    test_contention();
    test_lock();
    test_reset_midread();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
